// File: rtl/multi_rate_clk_gen.sv
// Multi-channel clock divider. Every channel counts CLK cycles up to its
// terminal count and then produces a one-cycle tick, plus an optional
// square wave. New settings are written to a per-channel shadow register
// and committed at the next terminal count, so a running period is never
// cut short. A disabled channel commits on the following cycle instead.
module multi_rate_clk_gen #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 24,
    parameter int DEF_DIV = 12_499_999,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [NUM_CH-1:0] en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic              cfg_mode,
    output logic [NUM_CH-1:0] slow_clk,
    output logic [NUM_CH-1:0] tick
);

    localparam logic [CNT_W-1:0] DEF_VAL = CNT_W'(DEF_DIV);

    logic [NUM_CH-1:0] pend_vec;

    // A channel takes a new write only once its previous write has committed;
    // indices with no channel behind them always accept (the write is dropped).
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = ~pend_vec[i];
            end
        end
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] act_div;
        logic [CNT_W-1:0] sh_div;
        logic             act_mode;
        logic             sh_mode;
        logic             pend;
        logic             slow_q;
        logic             tick_q;
        logic             tc;
        logic             wr_sel;

        // The >= keeps the counter from running past the terminal count.
        assign tc     = (cnt >= act_div);
        assign wr_sel = cfg_valid & cfg_ready & (cfg_ch == CH_W'(ch));

        // Counter, registered outputs and shadow-to-active commit for one channel
        always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) begin
                cnt      <= '0;
                act_div  <= DEF_VAL;
                sh_div   <= DEF_VAL;
                act_mode <= 1'b0;
                sh_mode  <= 1'b0;
                pend     <= 1'b0;
                slow_q   <= 1'b0;
                tick_q   <= 1'b0;
            end else begin
                if (wr_sel) begin
                    sh_div  <= cfg_div;
                    sh_mode <= cfg_mode;
                    pend    <= 1'b1;
                end
                if (!en[ch]) begin
                    cnt    <= '0;
                    slow_q <= 1'b0;
                    tick_q <= 1'b0;
                    if (pend) begin
                        act_div  <= sh_div;
                        act_mode <= sh_mode;
                        pend     <= 1'b0;
                    end
                end else begin
                    tick_q <= tc;
                    if (tc) begin
                        cnt <= '0;
                        if (pend) begin
                            act_div  <= sh_div;
                            act_mode <= sh_mode;
                            pend     <= 1'b0;
                            slow_q   <= (sh_mode | act_mode) ? 1'b0 : ~slow_q;
                        end else begin
                            slow_q <= act_mode ? 1'b0 : ~slow_q;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        if (act_mode) begin
                            slow_q <= 1'b0;
                        end
                    end
                end
            end
        end

        assign pend_vec[ch] = pend;
        assign slow_clk[ch] = slow_q;
        assign tick[ch]     = tick_q;
    end

endmodule
